vga_text_arbiter: RTL and testbench



---
 rtl/vga_text_arbiter_if.sv | 29 ++
 rtl/vga_text_arbiter.sv | 123 ++++++++++++
 tb/tb_vga_text_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_arbiter_if.sv
// Requester-side bundle for the text RAM arbiter: two req/ack ports plus the shared read result.
interface vga_text_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 7
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, ack1, rdata
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, ack1, rdata
  );
endinterface

// File: rtl/vga_text_arbiter.sv
// Round-robin arbiter sharing the single VGA text RAM port between the CPU path (port 0)
// and the glyph mover (port 1), with address range checking and read-latency wait.
//
// state  | meaning
// IDLE   | sample requests, grant one, drive RAM address/write for the grantee
// ISSUE  | RAM access cycle (mem_we high for an in-range write)
// RDWAIT | count down RD_LAT cycles, capture mem_rdata on the last one
// ACK    | one-cycle ack pulse to the granted port, then back to IDLE
module vga_text_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 7,
  parameter int MAX_ADDR = 2400,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  vga_text_arbiter_if.slave bus,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_t;

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MAX_ADDR);
  localparam logic [1:0]        LAT   = 2'(RD_LAT);

  state_t            state;
  logic              sel;
  logic              last;
  logic              t_we;
  logic              t_ok;
  logic [1:0]        cnt;
  logic              ack0_q;
  logic              ack1_q;
  logic [DATA_W-1:0] rdata_q;

  logic              any_req;
  logic              g_sel;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              g_ok;

  // On a tie the port that was not served last wins.
  always_comb begin
    any_req = bus.req0 | bus.req1;
    g_sel   = (bus.req0 && bus.req1) ? ~last : bus.req1;
    g_we    = g_sel ? bus.we1    : bus.we0;
    g_addr  = g_sel ? bus.addr1  : bus.addr0;
    g_wdata = g_sel ? bus.wdata1 : bus.wdata0;
    g_ok    = (g_addr < LIMIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      last      <= 1'b1;
      t_we      <= 1'b0;
      t_ok      <= 1'b0;
      cnt       <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rdata_q   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          mem_we <= 1'b0;
          if (any_req) begin
            sel       <= g_sel;
            last      <= g_sel;
            t_we      <= g_we;
            t_ok      <= g_ok;
            // Out-of-range accesses park the RAM at address 0 with the write dropped.
            mem_addr  <= g_ok ? g_addr : '0;
            mem_we    <= g_we & g_ok;
            mem_wdata <= g_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          if (t_we) begin
            ack0_q <= ~sel;
            ack1_q <= sel;
            state  <= ACK;
          end else begin
            cnt   <= LAT;
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          if (cnt == 2'd1) begin
            rdata_q <= t_ok ? mem_rdata : '0;
            ack0_q  <= ~sel;
            ack1_q  <= sel;
            state   <= ACK;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ACK: begin
          ack0_q <= 1'b0;
          ack1_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack0  = ack0_q;
  assign bus.ack1  = ack1_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_vga_text_arbiter.sv
// Bench for vga_text_arbiter: table vectors, randomized transactions against a
// transaction-level model, reset/fairness sequences and an RD_LAT=3 instance.
module tb_vga_text_arbiter;
  localparam int AW   = 14;
  localparam int DW   = 7;
  localparam int L    = 1;
  localparam int NONE = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  vga_text_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  vga_text_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

  logic          mem_we, mem_we3;
  logic [AW-1:0] mem_addr, mem_addr3;
  logic [DW-1:0] mem_wdata, mem_wdata3, mem_rdata, mem_rdata3;

  vga_text_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_ADDR(2400), .RD_LAT(L)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  vga_text_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_ADDR(2400), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3),
    .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  function automatic logic [DW-1:0] pat(int i);
    if (i == 100) return 7'd65;
    if (i == 0) return 7'd7;
    return DW'((i * 13 + 5) % 128);
  endfunction

  // RAMs with registered read ports: latency 1 for dut, 3 for dut3
  logic [DW-1:0] ram [0:16383];
  logic [DW-1:0] ram3 [0:16383];
  logic          ram_ready = 1'b0;
  logic [DW-1:0] rd_q, p1, p2, p3;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 16384; i++) begin
        ram[i]  <= pat(i);
        ram3[i] <= pat(i);
      end
      ram_ready <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_we3) ram3[mem_addr3] <= mem_wdata3;
    end
    rd_q <= ram[mem_addr];
    p1   <= ram3[mem_addr3];
    p2   <= p1;
    p3   <= p2;
  end
  assign mem_rdata  = rd_q;
  assign mem_rdata3 = p3;

  typedef struct {
    logic [1:0]         r;
    logic [1:0]         w;
    logic [1:0][AW-1:0] a;
    logic [1:0][DW-1:0] d;
    logic [1:0][7:0]    lat;
    logic [1:0][DW-1:0] rd;
    int                 nwr;
    int                 we_off;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(bit r0, bit w0, int a0, int d0, bit r1, bit w1, int a1, int d1,
                              int l0, int l1, int rd0, int rd1, int nwr, int we_off);
    vec_t v;
    v.r      = {r1, r0};
    v.w      = {w1, w0};
    v.a[0]   = AW'(a0);
    v.a[1]   = AW'(a1);
    v.d[0]   = DW'(d0);
    v.d[1]   = DW'(d1);
    v.lat[0] = 8'(l0);
    v.lat[1] = 8'(l1);
    v.rd[0]  = DW'(rd0);
    v.rd[1]  = DW'(rd1);
    v.nwr    = nwr;
    v.we_off = we_off;
    return v;
  endfunction

  // Transaction-level model: glyph contents, and which port was served last.
  logic [DW-1:0] ref_mem [0:2399];
  int            m_last;

  function automatic vec_t predict(input vec_t v);
    vec_t e;
    int   t;
    int   first;
    int   p;
    e        = v;
    e.lat    = {8'd255, 8'd255};
    e.rd     = '0;
    e.nwr    = 0;
    e.we_off = -1;
    t        = 0;
    first    = (v.r == 2'b11) ? 1 - m_last : (v.r[0] ? 0 : 1);
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? first : 1 - first;
      if (v.r[p]) begin
        m_last = p;
        if (v.w[p]) begin
          if (int'(v.a[p]) < 2400) begin
            ref_mem[int'(v.a[p])] = v.d[p];
            e.nwr++;
            if (e.we_off < 0) e.we_off = t + 1;
          end
          e.lat[p] = 8'(t + 2);
          t += 3;
        end else begin
          e.rd[p]  = (int'(v.a[p]) < 2400) ? ref_mem[int'(v.a[p])] : '0;
          e.lat[p] = 8'(t + 2 + L);
          t += 3 + L;
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, output vec_t act);
    int n;
    bit prev_we;
    bit ok;
    act        = v;
    act.lat    = {8'd255, 8'd255};
    act.rd     = '0;
    act.nwr    = 0;
    act.we_off = -1;
    prev_we    = 1'b0;
    @(negedge clk);
    n = cyc;
    bus.req0 = v.r[0]; bus.we0 = v.w[0]; bus.addr0 = v.a[0]; bus.wdata0 = v.d[0];
    bus.req1 = v.r[1]; bus.we1 = v.w[1]; bus.addr1 = v.a[1]; bus.wdata1 = v.d[1];
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus.ack0) begin
        act.lat[0] = (act.lat[0] == 8'd255) ? 8'(cyc - n) : 8'd254;
        act.rd[0]  = bus.rdata;
        bus.req0   = 1'b0;
      end
      if (bus.ack1) begin
        act.lat[1] = (act.lat[1] == 8'd255) ? 8'(cyc - n) : 8'd254;
        act.rd[1]  = bus.rdata;
        bus.req1   = 1'b0;
      end
      if (mem_we) begin
        act.nwr++;
        if (act.we_off < 0) act.we_off = cyc - n;
        ok = 1'b0;
        for (int p = 0; p < 2; p++)
          if (v.r[p] && v.w[p] && v.a[p] == mem_addr && v.d[p] == mem_wdata && int'(mem_addr) < 2400)
            ok = 1'b1;
        chk("mem_write_match", int'(ok), 1);
        chk("mem_we_single_cycle", int'(prev_we), 0);
      end
      prev_we = mem_we;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic cmp(input string tag, input vec_t act, input vec_t e);
    chk({tag, "_ack0_cycle"}, int'(act.lat[0]), int'(e.lat[0]));
    chk({tag, "_ack1_cycle"}, int'(act.lat[1]), int'(e.lat[1]));
    if (e.r[0] && !e.w[0]) chk({tag, "_rdata0"}, int'(act.rd[0]), int'(e.rd[0]));
    if (e.r[1] && !e.w[1]) chk({tag, "_rdata1"}, int'(act.rd[1]), int'(e.rd[1]));
    chk({tag, "_mem_we_count"}, act.nwr, e.nwr);
    chk({tag, "_mem_we_cycle"}, act.we_off, e.we_off);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return AW'($urandom_range(2400, 16383));
      1: return AW'(2399);
      2: return AW'(2400);
      3: return AW'($urandom_range(0, 15));
      default: return AW'($urandom_range(0, 2399));
    endcase
  endfunction

  task automatic rd3(input int addr, input int exp);
    int n;
    int k;
    int lat;
    int got;
    lat = -1;
    got = -1;
    @(negedge clk);
    n = cyc;
    bus3.req0 = 1'b1; bus3.we0 = 1'b0; bus3.addr0 = AW'(addr);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      k = cyc - n;
      if (k >= 2 && k <= 4) begin
        chk("rl3_addr_hold", int'(mem_addr3), addr);
        chk("rl3_no_we", int'(mem_we3), 0);
      end
      if (bus3.ack0) begin
        lat = k;
        got = int'(bus3.rdata);
        bus3.req0 = 1'b0;
      end
    end
    bus3.req0 = 1'b0;
    chk("rl3_ack_cycle", lat, 5);
    chk("rl3_rdata", got, exp);
  endtask

  initial begin
    vec_t act;
    vec_t e;
    vec_t v;
    int   n;
    int   quiet;
    int   rem [2];
    bit   pend [2];
    int   wr_k;
    int   order [$];

    reset = 1'b0;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    bus3.req0 = 0; bus3.we0 = 0; bus3.addr0 = '0; bus3.wdata0 = '0;
    bus3.req1 = 0; bus3.we1 = 0; bus3.addr1 = '0; bus3.wdata1 = '0;
    for (int i = 0; i < 2400; i++) ref_mem[i] = pat(i);
    m_last = 1;

    //           r0 w0 a0    d0  r1 w1 a1    d1  lat0 lat1 rd0 rd1 nwr we_off
    tbl[0] = mk(1, 1, 10,   3,  1, 1, 11,   4,  2,   5,   0,  0,  2,  1);
    tbl[1] = mk(0, 0, 0,    0,  1, 1, 2399, 32, NONE, 2,  0,  0,  1,  1);
    tbl[2] = mk(1, 0, 100,  0,  0, 0, 0,    0,  3, NONE,  65, 0,  0, -1);
    tbl[3] = mk(1, 1, 2400, 5,  0, 0, 0,    0,  2, NONE,  0,  0,  0, -1);
    tbl[4] = mk(0, 0, 0,    0,  1, 0, 8191, 0,  NONE, 3,  0,  0,  0, -1);
    tbl[5] = mk(1, 0, 10,   0,  0, 0, 0,    0,  3, NONE,  3,  0,  0, -1);
    tbl[6] = mk(1, 0, 2399, 0,  1, 0, 11,   0,  7,   3,   32, 4,  0, -1);
    tbl[7] = mk(1, 1, 100,  99, 1, 0, 100,  0,  6,   3,   0,  65, 1,  5);
    tbl[8] = mk(1, 0, 100,  0,  0, 0, 0,    0,  3, NONE,  99, 0,  0, -1);

    repeat (3) @(negedge clk);
    chk("reset_ack0", int'(bus.ack0), 0);
    chk("reset_ack1", int'(bus.ack1), 0);
    chk("reset_mem_we", int'(mem_we), 0);
    chk("reset_mem_addr", int'(mem_addr), 0);
    chk("reset_rdata", int'(bus.rdata), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i], act);
      e = predict(tbl[i]);
      cmp($sformatf("vec%0d", i), act, tbl[i]);
    end

    for (int i = 0; i < 200; i++) begin
      v.r = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        v.w[k] = 1'($urandom_range(0, 1));
        v.a[k] = rand_addr();
        v.d[k] = DW'($urandom());
      end
      e = predict(v);
      apply(v, act);
      cmp($sformatf("rnd%0d", i), act, e);
    end

    // Reset in the middle of a read
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = AW'(500); bus.req1 = 1'b0;
    @(negedge clk);
    chk("midrst_issue_addr", int'(mem_addr), 500);
    @(negedge clk);
    chk("midrst_rdwait_addr", int'(mem_addr), 500);
    reset = 1'b0;
    #1;
    chk("midrst_mem_addr", int'(mem_addr), 0);
    chk("midrst_mem_wdata", int'(mem_wdata), 0);
    chk("midrst_mem_we", int'(mem_we), 0);
    chk("midrst_ack0", int'(bus.ack0), 0);
    chk("midrst_rdata", int'(bus.rdata), 0);
    bus.req0 = 1'b0;
    m_last = 1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    quiet = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      quiet += int'(bus.ack0) + int'(bus.ack1) + int'(mem_we);
    end
    chk("midrst_no_activity", quiet, 0);

    // Both ports re-request continuously: grants must alternate starting with port 0
    rem[0] = 3; rem[1] = 3; pend[0] = 0; pend[1] = 0; wr_k = 0;
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = AW'(200); bus.wdata0 = 7'd1;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = AW'(300); bus.wdata1 = 7'd2;
    for (int c = 0; c < 60 && (rem[0] > 0 || rem[1] > 0); c++) begin
      @(negedge clk);
      wr_k++;
      if (pend[0] && rem[0] > 0) begin
        bus.req0 = 1'b1; bus.addr0 = AW'(200 + wr_k); bus.wdata0 = DW'(wr_k);
      end
      if (pend[1] && rem[1] > 0) begin
        bus.req1 = 1'b1; bus.addr1 = AW'(300 + wr_k); bus.wdata1 = DW'(wr_k);
      end
      pend[0] = 0;
      pend[1] = 0;
      if (bus.ack0) begin
        order.push_back(0); bus.req0 = 1'b0; rem[0]--; pend[0] = 1;
      end
      if (bus.ack1) begin
        order.push_back(1); bus.req1 = 1'b0; rem[1]--; pend[1] = 1;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    chk("fair_grant_count", order.size(), 6);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("fair_grant%0d", i), order[i], i % 2);

    rd3(0, 7);
    rd3(2000, int'(pat(2000)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
